// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants and the occupancy state type for the instruction-word stages.
package rv_pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam logic [31:0] NOP_IW = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/iw_skid_reg.sv
// Two-entry skid buffer (output register + skid register) with flush and a programmable idle value.
module iw_skid_reg
  import rv_pipe_pkg::*;
#(
  parameter int unsigned    W        = 8,
  parameter logic [W-1:0]   IDLE_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);

  occ_e         state;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      out_q  <= IDLE_VAL;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      out_q  <= IDLE_VAL;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            out_q <= din;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            skid_q <= din;
            state  <= FULL;
          end else if (push && pop) begin
            out_q <= din;
          end else if (pop) begin
            out_q <= IDLE_VAL;
            state <= EMPTY;
          end
        end
        FULL: begin
          // the skid word is always younger, so it refills the output register
          if (pop) begin
            out_q  <= skid_q;
            skid_q <= '0;
            state  <= ONE;
          end
        end
        default: begin
          state  <= EMPTY;
          out_q  <= IDLE_VAL;
          skid_q <= '0;
        end
      endcase
    end
  end

  assign dout  = out_q;
  assign valid = (state != EMPTY);
  assign full  = (state == FULL);

endmodule

// File: rtl/iw_select_stage.sv
// N-way instruction-word selector feeding decode through a registered, back-pressured skid buffer.
module iw_select_stage #(
  parameter int unsigned     XLEN   = rv_pipe_pkg::XLEN,
  parameter int unsigned     N_SRC  = 3,
  parameter int unsigned     SEL_W  = $clog2(N_SRC),
  parameter logic [XLEN-1:0] NOP_IW = XLEN'(rv_pipe_pkg::NOP_IW)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC*XLEN-1:0] src_iw,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [SEL_W-1:0]      sel,
  output logic                  in_ready,
  input  logic                  stall,
  input  logic                  flush,
  output logic [XLEN-1:0]       out_iw,
  output logic [SEL_W-1:0]      out_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  illegal_sel
);

  logic [XLEN-1:0]       cand [N_SRC];
  logic [XLEN-1:0]       sel_iw;
  logic                  sel_valid;
  logic                  sel_legal;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic [XLEN+SEL_W-1:0] din;
  logic [XLEN+SEL_W-1:0] dout;

  for (genvar g = 0; g < N_SRC; g++) begin : g_cand
    assign cand[g] = src_iw[g*XLEN +: XLEN];
  end

  // an out-of-range select matches no candidate and is accepted as a NOP
  always_comb begin
    sel_iw    = NOP_IW;
    sel_valid = 1'b1;
    sel_legal = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_iw    = cand[i];
        sel_valid = src_valid[i];
        sel_legal = 1'b1;
      end
    end
  end

  assign in_ready = !stall && !flush && !full;
  assign push     = sel_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign din      = sel_legal ? {sel_iw, sel} : {NOP_IW, {SEL_W{1'b0}}};

  iw_skid_reg #(
    .W        (XLEN + SEL_W),
    .IDLE_VAL ({NOP_IW, {SEL_W{1'b0}}})
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .valid (out_valid),
    .full  (full)
  );

  assign out_iw  = dout[SEL_W +: XLEN];
  assign out_src = dout[SEL_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_sel <= 1'b0;
    else     illegal_sel <= push && !sel_legal;
  end

endmodule

// File: tb/tb_iw_select_stage.sv
// Randomized scoreboard bench for iw_select_stage against a queue-based occupancy model.
module tb_iw_select_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned N_SRC = 3;
  localparam int unsigned SEL_W = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] iw;
    logic [1:0]  src;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_SRC*XLEN-1:0] src_iw;
  logic [N_SRC-1:0]      src_valid;
  logic [SEL_W-1:0]      sel;
  logic                  in_ready;
  logic                  stall;
  logic                  flush;
  logic [XLEN-1:0]       out_iw;
  logic [SEL_W-1:0]      out_src;
  logic                  out_valid;
  logic                  out_ready;
  logic                  illegal_sel;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  logic exp_ill = 1'b0;

  iw_select_stage #(
    .XLEN  (XLEN),
    .N_SRC (N_SRC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_iw      (src_iw),
    .src_valid   (src_valid),
    .sel         (sel),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .out_iw      (out_iw),
    .out_src     (out_src),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .illegal_sel (illegal_sel)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // monitor: compares the presented word with the oldest outstanding expectation
  always @(negedge clk) begin
    popped = 0;
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("out_iw", 64'(out_iw), 64'(sb[0].iw));
      chk("out_src", 64'(out_src), 64'(sb[0].src));
    end else begin
      chk("idle_iw", 64'(out_iw), 64'(NOP));
      chk("idle_src", 64'(out_src), 64'd0);
    end
    chk("illegal_sel", 64'(illegal_sel), 64'(exp_ill));
    if (sb.size() != 0 && out_ready && !flush && !rst) begin
      void'(sb.pop_front());
      popped = 1;
    end
  end

  // recorder: decides acceptance from the model occupancy and queues the expected word
  always @(negedge clk) begin
    int   occ;
    logic exp_rdy;
    logic in_v;
    ent_t e;
    #1;
    occ     = sb.size() + popped;
    exp_rdy = !stall && !flush && (occ < 2);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (rst) begin
      exp_ill = 1'b0;
    end else if (flush) begin
      sb.delete();
      exp_ill = 1'b0;
    end else begin
      in_v = (int'(sel) < N_SRC) ? src_valid[sel] : 1'b1;
      if (exp_rdy && in_v) begin
        if (int'(sel) < N_SRC) begin
          e.iw  = 32'(src_iw >> (int'(sel) * XLEN));
          e.src = sel;
        end else begin
          e.iw  = NOP;
          e.src = 2'd0;
        end
        sb.push_back(e);
        exp_ill = (int'(sel) >= N_SRC);
      end else begin
        exp_ill = 1'b0;
      end
    end
  end

  task automatic cyc(input logic [1:0] s, input logic [2:0] v, input logic r,
                     input logic st, input logic fl);
    @(posedge clk);
    #1;
    src_iw    = {$urandom, $urandom, $urandom};
    sel       = s;
    src_valid = v;
    out_ready = r;
    stall     = st;
    flush     = fl;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    exp_ill = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    src_iw = '0; src_valid = '0; sel = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (20) cyc(2'd1, 3'b111, 1'b1, 1'b0, 1'b0);   // stream
    repeat (3)  cyc(2'd1, 3'b010, 1'b0, 1'b0, 1'b0);   // back-pressure, fills
    repeat (6)  cyc(2'd0, 3'b000, 1'b1, 1'b0, 1'b0);   // drain
    cyc(2'd3, 3'b000, 1'b1, 1'b0, 1'b0);               // illegal select
    repeat (3)  cyc(2'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    repeat (2)  cyc(2'd2, 3'b100, 1'b0, 1'b0, 1'b0);   // fill to FULL
    cyc(2'd2, 3'b100, 1'b1, 1'b0, 1'b1);               // flush while full
    repeat (2)  cyc(2'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    cyc(2'd0, 3'b001, 1'b1, 1'b0, 1'b0);               // one word in
    repeat (3)  cyc(2'd0, 3'b001, 1'b1, 1'b1, 1'b0);   // stall drains it
    cyc(2'd1, 3'b010, 1'b0, 1'b0, 1'b0);
    mid_reset();
    repeat (2)  cyc(2'd0, 3'b000, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 500; i++) begin
      cyc(2'($urandom_range(0, 3)), 3'($urandom),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) < 3),
          ($urandom_range(0, 39) == 0));
      if (i == 250) mid_reset();
    end
    repeat (6) cyc(2'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
